// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch front end: PC generator, in-flight tag pipeline
//            for a fixed-latency instruction memory, and a DEPTH-entry queue.
//            Optional perf counters enabled by defining FETCH_QUEUE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          LATENCY      = 2,
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_PC     = 32'h0000_0400,
  parameter logic [7:0]  MISALIGN_EXC = 8'h84
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        redirect_int,
  input  logic [31:0] int_vector,
  input  logic        redirect_br,
  input  logic [31:0] br_tgt,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic [7:0]  mem_exc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [7:0]  out_exc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_redirects
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  typedef struct packed {
    logic        vld;
    logic        ep;
    logic [31:0] pc;
    logic        mis;
  } tag_t;

  logic [31:0]   r_pc;
  logic          r_epoch;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  tag_t          r_pipe [LATENCY];
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];
  logic [7:0]    r_q_exc   [DEPTH];

  logic          w_redirect;
  logic [31:0]   w_target;
  logic [SW-1:0] w_sum;
  logic          w_credit;
  tag_t          w_exit;
  tag_t          w_new_tag;
  logic          w_exit_cur;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_push_exc;
  logic [CW-1:0] w_count_n;
  logic [CW-1:0] w_after_pop;
  logic [AW-1:0] w_rptr_n;
  logic [31:0]   w_head_instr;
  logic [31:0]   w_head_pc;
  logic [7:0]    w_head_exc;

  assign w_redirect = redirect_int | redirect_br;
  assign w_target   = redirect_int ? int_vector : br_tgt;
  assign mem_addr   = redirect_int ? int_vector : (redirect_br ? br_tgt : r_pc);

  // A redirect flushes queue and tracker this cycle, so it always has credit.
  assign w_sum    = SW'(r_count) + SW'(r_inflight);
  assign w_credit = w_redirect | (w_sum < SW'(DEPTH));
  assign mem_req  = ~rst & clk_en & w_credit;

  assign w_exit     = r_pipe[LATENCY-1];
  assign w_exit_cur = w_exit.vld & (w_exit.ep == r_epoch);
  assign w_push     = w_exit_cur & ~w_redirect;
  assign w_pop      = out_valid & out_ready & ~w_redirect;
  assign w_push_exc = w_exit.mis ? MISALIGN_EXC : mem_exc;

  assign w_new_tag.vld = mem_req;
  assign w_new_tag.ep  = w_redirect ? ~r_epoch : r_epoch;
  assign w_new_tag.pc  = mem_addr;
  assign w_new_tag.mis = |mem_addr[1:0];

  assign w_count_n   = r_count + CW'(w_push) - CW'(w_pop);
  assign w_after_pop = r_count - CW'(w_pop);
  assign w_rptr_n    = r_rptr + AW'(w_pop);

  // Next head comes from the incoming response when nothing else remains.
  always_comb begin
    w_head_instr = r_q_instr[w_rptr_n];
    w_head_pc    = r_q_pc[w_rptr_n];
    w_head_exc   = r_q_exc[w_rptr_n];
    if (w_after_pop == '0) begin
      w_head_instr = mem_rdata;
      w_head_pc    = w_exit.pc;
      w_head_exc   = w_push_exc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_epoch    <= 1'b0;
      r_inflight <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else if (clk_en) begin
      if (mem_req)         r_pc <= mem_addr + 32'd4;
      else if (w_redirect) r_pc <= w_target;

      if (w_redirect) begin
        r_epoch    <= ~r_epoch;
        r_inflight <= CW'(mem_req);
      end else begin
        r_inflight <= r_inflight + CW'(mem_req) - CW'(w_exit_cur);
      end

      r_pipe[0] <= w_new_tag;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && w_push) begin
      r_q_instr[r_wptr] <= mem_rdata;
      r_q_pc[r_wptr]    <= w_exit.pc;
      r_q_exc[r_wptr]   <= w_push_exc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_rptr    <= '0;
      r_wptr    <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_exc   <= '0;
    end else if (clk_en) begin
      if (w_redirect) begin
        r_count   <= '0;
        r_rptr    <= '0;
        r_wptr    <= '0;
        out_valid <= 1'b0;
      end else begin
        r_count   <= w_count_n;
        r_rptr    <= w_rptr_n;
        r_wptr    <= r_wptr + AW'(w_push);
        out_valid <= (w_count_n != '0);
        if (w_count_n != '0) begin
          out_instr <= w_head_instr;
          out_pc    <= w_head_pc;
          out_exc   <= w_head_exc;
        end
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_dropped   <= '0;
      perf_redirects <= '0;
    end else if (clk_en) begin
      perf_fetched   <= perf_fetched + 32'(w_push);
      perf_dropped   <= perf_dropped + 32'(w_exit.vld & ~w_push)
                        + (w_redirect ? 32'(r_count) : 32'd0);
      perf_redirects <= perf_redirects + 32'(w_redirect);
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(clk_en && w_push && !w_pop && r_count == CW'(DEPTH)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed scoreboard bench for fetch_queue (LATENCY=2, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int LAT = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        redirect_int = 1'b0;
  logic [31:0] int_vector = '0;
  logic        redirect_br = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  mem_exc;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [7:0]  out_exc;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_redirects;
`endif

  fetch_queue #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .redirect_int(redirect_int), .int_vector(int_vector),
    .redirect_br(redirect_br), .br_tgt(br_tgt),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_exc(mem_exc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped),
    .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [7:0] exc_of(input logic [31:0] a);
    return (a == 32'h2002 || a == 32'h3000) ? 8'h22 : 8'h00;
  endfunction

  // Fixed-latency memory: answers with the address seen LAT enabled cycles ago.
  logic [31:0] r_hist [LAT];
  always @(posedge clk) begin
    if (clk_en) begin
      r_hist[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) r_hist[i] <= r_hist[i-1];
    end
  end
  assign mem_rdata = fdata(r_hist[LAT-1]);
  assign mem_exc   = exc_of(r_hist[LAT-1]);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  exc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;
  bit   seen2000 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [7:0] exc);
    exp_t e;
    e.pc    = pc;
    e.instr = fdata(pc);
    e.exc   = exc;
    sb.push_back(e);
  endtask

  // Monitor: every accepted head is popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst && clk_en && out_valid && out_ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected none", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        chk("out_exc", 32'(out_exc), 32'(e.exc));
      end
    end
    if (!rst && mem_req && mem_addr == 32'h2000) seen2000 = 1'b1;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    clk_en = 1'b1;
    redirect_int = 1'b0;
    redirect_br = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_exc", 32'(out_exc), 32'd0);

    // Streaming with out_ready held high
    do_reset(1'b1);
    for (int k = 0; k < 7; k++) push_exp(32'h400 + 32'(4 * k), 8'h00);
    base = n_pop;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 3) begin
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_addr", mem_addr, 32'h400 + 32'(4 * c));
        chk("t1_not_valid", 32'(out_valid), 32'd0);
      end
      if (c == 3) chk("t1_first_pc", out_pc, 32'h400);
      if (c >= 3) chk("t1_valid", 32'(out_valid), 32'd1);
      next_cyc();
    end
    chk("t1_pops", 32'(n_pop - base), 32'd7);

    // Stalled decode fills the queue, clk_en=0 freezes everything
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        chk("t2_req", 32'(mem_req), 32'd1);
        chk("t2_addr", mem_addr, 32'h400 + 32'(4 * c));
      end else begin
        chk("t2_idle", 32'(mem_req), 32'd0);
      end
      next_cyc();
    end
    @(negedge clk);
    chk("t2_full_valid", 32'(out_valid), 32'd1);
    chk("t2_full_pc", out_pc, 32'h400);
    next_cyc();
    clk_en = 1'b0;
    redirect_br = 1'b1;
    br_tgt = 32'h2000;
    @(negedge clk);
    chk("t2_clken_req", 32'(mem_req), 32'd0);
    next_cyc();
    next_cyc();
    clk_en = 1'b1;
    redirect_br = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) push_exp(32'h400 + 32'(4 * k), 8'h00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) chk("t2_no_credit", 32'(mem_req), 32'd0);
      if (k == 1) begin
        chk("t2_resume_req", 32'(mem_req), 32'd1);
        chk("t2_resume_addr", mem_addr, 32'h410);
      end
      next_cyc();
    end

    // Branch redirect with two fetches in flight
    do_reset(1'b1);
    push_exp(32'h2000, 8'h00);
    push_exp(32'h2004, 8'h00);
    push_exp(32'h2008, 8'h00);
    for (int c = 0; c < 8; c++) begin
      redirect_br = (c == 2);
      br_tgt = 32'h2000;
      @(negedge clk);
      if (c == 2) chk("t3_redir_addr", mem_addr, 32'h2000);
      if (c == 3) begin
        chk("t3_flush_valid", 32'(out_valid), 32'd0);
        chk("t3_next_addr", mem_addr, 32'h2004);
      end
      if (c == 4) chk("t3_wait_valid", 32'(out_valid), 32'd0);
      if (c == 5) begin
        chk("t3_tgt_valid", 32'(out_valid), 32'd1);
        chk("t3_tgt_pc", out_pc, 32'h2000);
      end
      next_cyc();
    end
    redirect_br = 1'b0;

    // Interrupt and branch in the same cycle: interrupt wins
    do_reset(1'b1);
    seen2000 = 1'b0;
    for (int k = 0; k < 4; k++) push_exp(32'h100 + 32'(4 * k), 8'h00);
    for (int c = 0; c < 7; c++) begin
      redirect_int = (c == 0);
      redirect_br = (c == 0);
      int_vector = 32'h100;
      br_tgt = 32'h2000;
      @(negedge clk);
      if (c == 0) chk("t4_int_addr", mem_addr, 32'h100);
      if (c == 1) chk("t4_next_addr", mem_addr, 32'h104);
      next_cyc();
    end
    redirect_int = 1'b0;
    redirect_br = 1'b0;
    chk("t4_no_2000", 32'(seen2000), 32'd0);

    // Misaligned target overrides mem_exc; aligned fetch passes mem_exc
    do_reset(1'b1);
    push_exp(32'h2002, 8'h84);
    push_exp(32'h2006, 8'h84);
    push_exp(32'h200A, 8'h84);
    push_exp(32'h3000, 8'h22);
    push_exp(32'h3004, 8'h00);
    for (int c = 0; c < 11; c++) begin
      redirect_br = (c == 0) || (c == 6);
      br_tgt = (c == 6) ? 32'h3000 : 32'h2002;
      out_ready = (c != 6);
      @(negedge clk);
      if (c == 0) chk("t5_mis_addr", mem_addr, 32'h2002);
      if (c == 7) chk("t5_flush_valid", 32'(out_valid), 32'd0);
      next_cyc();
    end
    redirect_br = 1'b0;

    // Asynchronous reset with a full queue
    do_reset(1'b0);
    for (int c = 0; c < 6; c++) next_cyc();
    @(negedge clk);
    chk("t6_full_valid", 32'(out_valid), 32'd1);
    chk("t6_full_req", 32'(mem_req), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_req", 32'(mem_req), 32'd0);
    chk("t6_async_pc", out_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    push_exp(32'h400, 8'h00);
    push_exp(32'h404, 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("t6_restart_req", 32'(mem_req), 32'd1);
        chk("t6_restart_addr", mem_addr, 32'h400);
      end
      if (c < 3) chk("t6_no_stale", 32'(out_valid), 32'd0);
      next_cyc();
    end
    out_ready = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
